aging_warn_ctrl: RTL and testbench

AGING_WARN_CTRL -- requirements
Module: aging_warn_ctrl

---
 rtl/aging_warn_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_aging_warn_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aging_warn_ctrl.sv
// ---------------------------------------------------------------------------
// aging_warn_ctrl
//
// Watches an asynchronous warning line from an aging monitor, counts how many
// cycles it is asserted during fixed-length observation epochs, and raises an
// alarm plus a single frequency-reduction request once enough consecutive
// epochs have been "bad".
//
// Parameters
//   EPOCH_LEN  clk cycles per observation epoch (>= 2)
//   THRESH     warning-cycle count at or above which an epoch is bad
//   PERSIST    consecutive bad epochs needed to raise the alarm (>= 1)
//   CNT_W      width of the warning-cycle counters
//
// Ports
//   clk            system clock, all state changes on its rising edge
//   rst_n          asynchronous active-low reset
//   warning_in     asynchronous warning from the aging monitor
//   enable         level, 1 = monitor epochs, 0 = idle
//   clear_alarm    one-cycle pulse that releases the alarm
//   freq_down_ack  acknowledge from the clock controller
//   aging_alarm    high while the FSM is in ALARM
//   freq_down_req  frequency-reduction request, held until acknowledged
//   epoch_done     one-cycle pulse after each completed epoch
//   last_count     warning-cycle count of the last completed epoch
//   state          FSM state: IDLE=0, MONITOR=1, ALARM=2
// ---------------------------------------------------------------------------
module aging_warn_ctrl #(
  parameter int EPOCH_LEN = 1024,
  parameter int THRESH    = 4,
  parameter int PERSIST   = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             warning_in,
  input  logic             enable,
  input  logic             clear_alarm,
  input  logic             freq_down_ack,
  output logic             aging_alarm,
  output logic             freq_down_req,
  output logic             epoch_done,
  output logic [CNT_W-1:0] last_count,
  output logic [1:0]       state
);

  localparam int EPOCH_W = (EPOCH_LEN > 2) ? $clog2(EPOCH_LEN) : 1;
  localparam int BAD_W   = $clog2(PERSIST + 1);

  localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(EPOCH_LEN - 1);
  localparam logic [BAD_W-1:0]   BAD_MAX    = BAD_W'(PERSIST);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_ALARM   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic               sync_ff1;
  logic               warn_s;
  logic [EPOCH_W-1:0] epoch_cnt;
  logic [CNT_W-1:0]   hit_cnt;
  logic [BAD_W-1:0]   bad_cnt;

  logic               monitoring;
  logic               epoch_end;
  logic [CNT_W-1:0]   hit_final;
  logic               epoch_bad;
  logic [BAD_W-1:0]   bad_next;
  logic               alarm_trip;
  logic               alarm_entry;
  logic               clear_ok;

  // Two-flop synchronizer bringing the asynchronous warning into the clk
  // domain; warn_s lags warning_in by two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1 <= 1'b0;
      warn_s   <= 1'b0;
    end else begin
      sync_ff1 <= warning_in;
      warn_s   <= sync_ff1;
    end
  end

  // Epoch bookkeeping shared by the FSM and the datapath. hit_final is the
  // count including this cycle's warning, saturated so it never wraps.
  // A bad epoch pushes bad_cnt toward PERSIST; a good one forgets history.
  always_comb begin
    monitoring = (state_q == ST_MONITOR) && enable;
    epoch_end  = monitoring && (epoch_cnt == EPOCH_LAST);

    hit_final = hit_cnt;
    if (warn_s && (hit_cnt != {CNT_W{1'b1}})) begin
      hit_final = hit_cnt + 1'b1;
    end

    epoch_bad = (32'(hit_final) >= 32'(THRESH));

    bad_next = '0;
    if (epoch_bad) begin
      if (bad_cnt == BAD_MAX) begin
        bad_next = BAD_MAX;
      end else begin
        bad_next = bad_cnt + 1'b1;
      end
    end

    alarm_trip = epoch_end && (bad_next == BAD_MAX);
    clear_ok   = clear_alarm && (!freq_down_req || freq_down_ack);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. Dropping enable wins over an epoch end on the
  // same edge, so that epoch is discarded rather than judged. In ALARM the
  // enable level is ignored; only an allowed clear leaves. The unused
  // encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_MONITOR;
        end
      end
      ST_MONITOR: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (alarm_trip) begin
          state_d = ST_ALARM;
        end
      end
      ST_ALARM: begin
        if (clear_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    aging_alarm = (state_q == ST_ALARM);
    state       = state_q;
    alarm_entry = (state_q == ST_MONITOR) && (state_d == ST_ALARM);
  end

  // Epoch, hit and bad-epoch counters. IDLE keeps them cleared so every
  // MONITOR entry starts a fresh epoch with no bad-epoch history. ALARM
  // freezes them. Leaving MONITOR through enable=0 throws away the partial
  // epoch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_cnt <= '0;
      hit_cnt   <= '0;
      bad_cnt   <= '0;
    end else begin
      case (state_q)
        ST_MONITOR: begin
          if (!enable) begin
            epoch_cnt <= '0;
            hit_cnt   <= '0;
            bad_cnt   <= '0;
          end else if (epoch_end) begin
            epoch_cnt <= '0;
            hit_cnt   <= '0;
            bad_cnt   <= bad_next;
          end else begin
            epoch_cnt <= epoch_cnt + 1'b1;
            hit_cnt   <= hit_final;
          end
        end
        ST_ALARM: begin
          epoch_cnt <= epoch_cnt;
          hit_cnt   <= hit_cnt;
          bad_cnt   <= bad_cnt;
        end
        default: begin
          epoch_cnt <= '0;
          hit_cnt   <= '0;
          bad_cnt   <= '0;
        end
      endcase
    end
  end

  // Epoch result publishing: the finished count is captured on the closing
  // edge and epoch_done is high for exactly the following cycle. last_count
  // is otherwise left alone so it survives IDLE and ALARM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_done <= 1'b0;
      last_count <= '0;
    end else begin
      epoch_done <= epoch_end;
      if (epoch_end) begin
        last_count <= hit_final;
      end
    end
  end

  // Frequency-reduction request: raised once per alarm entry, dropped on
  // the edge where the clock controller acknowledges. An ack arriving while
  // no request is pending has nothing to act on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_down_req <= 1'b0;
    end else if (alarm_entry) begin
      freq_down_req <= 1'b1;
    end else if (freq_down_req && freq_down_ack) begin
      freq_down_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aging_warn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aging_warn_ctrl
//
// Directed bench for aging_warn_ctrl with EPOCH_LEN=8, THRESH=2, PERSIST=2.
// A main instance uses CNT_W=4; a second instance with CNT_W=3 shares the
// same stimulus so count saturation can be observed. Expected epoch counts
// are queued when an epoch's warnings are driven and popped whenever the
// main instance pulses epoch_done.
// ---------------------------------------------------------------------------
module tb_aging_warn_ctrl;

  localparam int EL  = 8;
  localparam int TH  = 2;
  localparam int PS  = 2;
  localparam int CW  = 4;
  localparam int CWS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          warning_in;
  logic          enable;
  logic          clear_alarm;
  logic          freq_down_ack;

  logic          aging_alarm;
  logic          freq_down_req;
  logic          epoch_done;
  logic [CW-1:0] last_count;
  logic [1:0]    state;

  logic           sat_alarm;
  logic           sat_req;
  logic           sat_done;
  logic [CWS-1:0] sat_last;
  logic [1:0]     sat_state;

  typedef struct {
    int count;
    int gap;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int done_count = 0;
  int done_before = 0;

  aging_warn_ctrl #(.EPOCH_LEN(EL), .THRESH(TH), .PERSIST(PS), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .warning_in    (warning_in),
    .enable        (enable),
    .clear_alarm   (clear_alarm),
    .freq_down_ack (freq_down_ack),
    .aging_alarm   (aging_alarm),
    .freq_down_req (freq_down_req),
    .epoch_done    (epoch_done),
    .last_count    (last_count),
    .state         (state)
  );

  aging_warn_ctrl #(.EPOCH_LEN(EL), .THRESH(TH), .PERSIST(PS), .CNT_W(CWS)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .warning_in    (warning_in),
    .enable        (enable),
    .clear_alarm   (clear_alarm),
    .freq_down_ack (freq_down_ack),
    .aging_alarm   (sat_alarm),
    .freq_down_req (sat_req),
    .epoch_done    (sat_done),
    .last_count    (sat_last),
    .state         (sat_state)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One comparison: counts it, and on mismatch counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and return at the following falling edge.
  task automatic applyStimulus(input logic en, input logic warn, input logic clr, input logic ack);
    enable        = en;
    warning_in    = warn;
    clear_alarm   = clr;
    freq_down_ack = ack;
    @(negedge clk);
  endtask

  // Eight enabled cycles with warnings on cycles 1..nwarn; the two-cycle
  // synchronizer lag keeps them inside the matching DUT epoch.
  task automatic driveEpoch(input int nwarn);
    for (int i = 0; i < EL; i++) begin
      applyStimulus(1'b1, (i >= 1) && (i <= nwarn), 1'b0, 1'b0);
    end
  endtask

  task automatic expectEpoch(input int count, input int gap);
    exp_t e;
    e.count = count;
    e.gap   = gap;
    sb_q.push_back(e);
  endtask

  // Scoreboard consumer: every epoch_done pops one expectation.
  always @(negedge clk) begin
    if (epoch_done === 1'b1) begin
      done_count++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL unexpected_epoch_done observed=1 expected=0");
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("sb_last_count", last_count, mon_e.count);
        if (mon_e.gap != 0) begin
          checkOutput("sb_epoch_gap", cyc - last_done_cyc, mon_e.gap);
        end
      end
      last_done_cyc = cyc;
    end
  end

  // Hard bound on simulation time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    warning_in    = 1'b0;
    enable        = 1'b0;
    clear_alarm   = 1'b0;
    freq_down_ack = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_state", state, 0);
    checkOutput("rst_alarm", aging_alarm, 0);
    checkOutput("rst_req", freq_down_req, 0);
    checkOutput("rst_done", epoch_done, 0);
    checkOutput("rst_last", last_count, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("idle_hold", state, 0);

    $display("[TB] quiet epochs");
    expectEpoch(0, 0);
    expectEpoch(0, 8);
    expectEpoch(0, 8);
    applyStimulus(1, 0, 0, 0);
    checkOutput("a_enter_mon", state, 1);
    for (int i = 0; i < 3 * EL; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("a_no_alarm", aging_alarm, 0);
    checkOutput("a_still_mon", state, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("a_to_idle", state, 0);

    $display("[TB] two bad epochs raise alarm");
    expectEpoch(3, 0);
    expectEpoch(3, 8);
    driveEpoch(3);
    driveEpoch(3);
    applyStimulus(1, 0, 0, 0);
    checkOutput("b_state", state, 2);
    checkOutput("b_alarm", aging_alarm, 1);
    checkOutput("b_req", freq_down_req, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("b_enable_ignored", state, 2);
    checkOutput("b_req_held", freq_down_req, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("b_req_acked", freq_down_req, 0);
    checkOutput("b_alarm_after_ack", aging_alarm, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("b_ack_no_req", freq_down_req, 0);
    checkOutput("b_state_no_req", state, 2);
    applyStimulus(0, 0, 1, 0);
    checkOutput("b_cleared", state, 0);
    checkOutput("b_alarm_off", aging_alarm, 0);
    checkOutput("b_last_kept", last_count, 3);
    applyStimulus(0, 0, 1, 0);
    checkOutput("b_clear_in_idle", state, 0);

    $display("[TB] bad good bad");
    expectEpoch(2, 0);
    expectEpoch(1, 8);
    expectEpoch(2, 8);
    driveEpoch(2);
    driveEpoch(1);
    driveEpoch(2);
    applyStimulus(1, 0, 0, 0);
    checkOutput("c_no_alarm", aging_alarm, 0);
    checkOutput("c_state", state, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("c_to_idle", state, 0);

    $display("[TB] clear with pending request");
    expectEpoch(2, 0);
    expectEpoch(2, 8);
    driveEpoch(2);
    driveEpoch(2);
    applyStimulus(1, 0, 0, 0);
    checkOutput("d_state", state, 2);
    checkOutput("d_req", freq_down_req, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("d_clear_ignored", state, 2);
    applyStimulus(0, 0, 0, 0);
    checkOutput("d_clear_not_kept", state, 2);
    applyStimulus(0, 0, 1, 1);
    checkOutput("d_clear_ack_state", state, 0);
    checkOutput("d_clear_ack_alarm", aging_alarm, 0);
    checkOutput("d_clear_ack_req", freq_down_req, 0);

    $display("[TB] saturation");
    expectEpoch(8, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < EL; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("e_last_wide", last_count, 8);
    checkOutput("e_last_sat", sat_last, 7);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] partial epoch discarded");
    done_before = done_count;
    for (int i = 0; i < 5; i++) applyStimulus(1, (i >= 1) && (i <= 3), 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("f_no_done", done_count - done_before, 0);
    checkOutput("f_last_kept", last_count, 8);
    checkOutput("f_state", state, 0);

    $display("[TB] reset with request pending");
    expectEpoch(2, 0);
    expectEpoch(2, 8);
    driveEpoch(2);
    driveEpoch(2);
    applyStimulus(1, 0, 0, 0);
    checkOutput("h_req_before", freq_down_req, 1);
    enable = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("h_rst_req", freq_down_req, 0);
    checkOutput("h_rst_alarm", aging_alarm, 0);
    checkOutput("h_rst_state", state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("h_after_rst", state, 0);

    $display("[TB] reset mid-epoch");
    for (int i = 0; i < 7; i++) applyStimulus(1, (i >= 1) && (i <= 5), 0, 0);
    enable     = 1'b0;
    warning_in = 1'b0;
    rst_n      = 1'b0;
    #1;
    checkOutput("g_rst_state", state, 0);
    checkOutput("g_rst_alarm", aging_alarm, 0);
    checkOutput("g_rst_req", freq_down_req, 0);
    checkOutput("g_rst_done", epoch_done, 0);
    checkOutput("g_rst_last", last_count, 0);
    checkOutput("g_rst_last_sat", sat_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("g_idle_after_rst", state, 0);
    expectEpoch(1, 0);
    driveEpoch(1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("g_fresh_last", last_count, 1);

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
